vga_sync_gen: RTL and testbench

Raster timing generator that consumes the one-CLK-wide pixel-enable pulse from the pixel clock divider and produces VGA horizontal/vertical sync, an active-video flag and the current pixel coordinates. It sits directly downstream of the divider and upstream of the frame-buffer read / colour output stage. All logic runs on CLK; the raster advances by one pixel only on CLK edges where PIX_EN is high. Defaults give 640x480 @ 60 Hz from a 100 MHz CLK with PIX_EN every 4th cycle.

---
 rtl/vga_sync_gen.sv | 91 +++++++++
 tb/tb_vga_sync_gen.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_gen.sv
// VGA raster timing: pixel/line counters advanced by PIX_EN, with
// registered sync, active-video, coordinate and frame-start outputs.
module vga_sync_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int SYNC_POL = 0
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       PIX_EN,
    output logic       HSYNC,
    output logic       VSYNC,
    output logic       VIDEO_ON,
    output logic [9:0] PIX_X,
    output logic [9:0] PIX_Y,
    output logic       FRAME_START
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
    localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic       SYNC_ON = (SYNC_POL != 0);

    logic [9:0] h_q, h_d;
    logic [9:0] v_q, v_d;
    logic       hs_q, hs_d;
    logic       vs_q, vs_d;
    logic       vid_q, vid_d;
    logic       fs_q, fs_d;

    always_comb begin
        h_d = h_q;
        v_d = v_q;
        if (PIX_EN) begin
            if (h_q == H_LAST) begin
                h_d = 10'd0;
                v_d = (v_q == V_LAST) ? 10'd0 : v_q + 10'd1;
            end else begin
                h_d = h_q + 10'd1;
            end
        end
    end

    // Flags decode the next-state counters so they line up with PIX_X/PIX_Y.
    always_comb begin
        hs_d  = ((h_d >= HS_BEG) && (h_d <= HS_END)) ? SYNC_ON : ~SYNC_ON;
        vs_d  = ((v_d >= VS_BEG) && (v_d <= VS_END)) ? SYNC_ON : ~SYNC_ON;
        vid_d = (h_d < H_ACT) && (v_d < V_ACT);
        fs_d  = PIX_EN && (h_d == 10'd0) && (v_d == 10'd0);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            h_q   <= H_LAST;
            v_q   <= V_LAST;
            hs_q  <= ~SYNC_ON;
            vs_q  <= ~SYNC_ON;
            vid_q <= 1'b0;
            fs_q  <= 1'b0;
        end else begin
            h_q   <= h_d;
            v_q   <= v_d;
            hs_q  <= hs_d;
            vs_q  <= vs_d;
            vid_q <= vid_d;
            fs_q  <= fs_d;
        end
    end

    assign HSYNC       = hs_q;
    assign VSYNC       = vs_q;
    assign VIDEO_ON    = vid_q;
    assign PIX_X       = h_q;
    assign PIX_Y       = v_q;
    assign FRAME_START = fs_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench: default 640x480 instance plus a tiny
// active-high-sync instance for whole-frame behaviour.
module tb_vga_sync_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, pen;
    logic       hs, vs, von, fs;
    logic [9:0] px, py;

    logic       srst, spen;
    logic       s_hs, s_vs, s_von, s_fs;
    logic [9:0] s_px, s_py;

    int errs   = 0;
    int checks = 0;

    vga_sync_gen u_dut (
        .CLK(clk), .RST(rst), .PIX_EN(pen),
        .HSYNC(hs), .VSYNC(vs), .VIDEO_ON(von),
        .PIX_X(px), .PIX_Y(py), .FRAME_START(fs)
    );

    // 16 x 11 raster, sync active-high
    vga_sync_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2),
        .SYNC_POL(1)
    ) u_small (
        .CLK(clk), .RST(srst), .PIX_EN(spen),
        .HSYNC(s_hs), .VSYNC(s_vs), .VIDEO_ON(s_von),
        .PIX_X(s_px), .PIX_Y(s_py), .FRAME_START(s_fs)
    );

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick(input logic en);
        pen = en;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int hlow, vlow, bad, shc, svc, svid, sfs, smaxy;
        bit seen;
        rst  = 1'b1;
        pen  = 1'b0;
        srst = 1'b1;
        spen = 1'b0;
        repeat (3) tick(1'b0);

        check("rst_x", px, 799);
        check("rst_y", py, 524);
        check("rst_hs", hs, 1);
        check("rst_vs", vs, 1);
        check("rst_von", von, 0);
        check("rst_fs", fs, 0);
        check("s_rst_x", s_px, 15);
        check("s_rst_y", s_py, 10);
        check("s_rst_hs", s_hs, 0);
        check("s_rst_vs", s_vs, 0);

        rst = 1'b0;
        tick(1'b0);
        check("idle_x", px, 799);
        tick(1'b1);
        check("first_x", px, 0);
        check("first_y", py, 0);
        check("first_fs", fs, 1);
        check("first_von", von, 1);
        check("first_hs", hs, 1);
        tick(1'b0);
        check("fs_one_clk", fs, 0);
        check("hold00_x", px, 0);

        // one line at 1-in-4 enable
        hlow = 0;
        vlow = 0;
        seen = 0;
        for (int p = 1; p < 800; p++) begin
            for (int c = 0; c < 4; c++) begin
                tick(c == 0);
                if (!hs) begin
                    hlow++;
                    if (!seen) begin
                        seen = 1;
                        check("hs_first_x", px, 656);
                    end
                end
                if (!von) vlow++;
            end
        end
        check("hs_low_clk", hlow, 384);
        check("von_low_clk", vlow, 640);
        check("line_end_x", px, 799);
        check("line_end_y", py, 0);
        tick(1'b1);
        check("wrap1_x", px, 0);
        check("wrap1_y", py, 1);
        check("wrap1_fs", fs, 0);

        // continuous enable: one pixel per CLK
        repeat (799) tick(1'b1);
        check("cont_x", px, 799);
        check("cont_y", py, 1);
        tick(1'b1);
        check("cont_wrap_x", px, 0);
        check("cont_wrap_y", py, 2);
        repeat (7055) tick(1'b1);
        check("pre_hold_x", px, 655);
        check("pre_hold_y", py, 10);
        check("pre_hold_hs", hs, 1);
        check("pre_hold_von", von, 0);

        bad = 0;
        for (int i = 0; i < 100; i++) begin
            tick(1'b0);
            if (px !== 10'd655 || py !== 10'd10 || hs !== 1'b1 ||
                vs !== 1'b1 || von !== 1'b0 || fs !== 1'b0)
                bad++;
        end
        check("hold_stable", bad, 0);
        tick(1'b1);
        check("post_hold_x", px, 656);
        check("post_hold_hs", hs, 0);
        check("post_hold_vs", vs, 1);

        repeat (444) tick(1'b1);
        check("mid_x", px, 300);
        check("mid_y", py, 11);
        check("mid_von", von, 1);
        pen = 1'b0;

        // asynchronous reset between edges
        #2;
        rst = 1'b1;
        #1;
        check("arst_x", px, 799);
        check("arst_y", py, 524);
        check("arst_von", von, 0);
        check("arst_hs", hs, 1);
        check("arst_vs", vs, 1);
        check("arst_fs", fs, 0);
        tick(1'b1);
        tick(1'b0);
        rst = 1'b0;
        tick(1'b0);
        check("rel_x", px, 799);
        check("rel_fs", fs, 0);
        tick(1'b1);
        check("restart_x", px, 0);
        check("restart_y", py, 0);
        check("restart_fs", fs, 1);
        tick(1'b0);
        check("restart_fs_end", fs, 0);

        // small raster: two frames, 1-in-2 enable
        srst = 1'b0;
        tick(1'b0);
        shc   = 0;
        svc   = 0;
        svid  = 0;
        sfs   = 0;
        smaxy = 0;
        for (int i = 0; i < 704; i++) begin
            spen = (i % 2 == 0);
            @(posedge clk);
            #1;
            if (i == 0) begin
                check("s_first_x", s_px, 0);
                check("s_first_y", s_py, 0);
                check("s_first_fs", s_fs, 1);
            end
            if (s_hs) shc++;
            if (s_vs) svc++;
            if (s_von) svid++;
            if (s_fs) sfs++;
            if (int'(s_py) > smaxy) smaxy = int'(s_py);
        end
        spen = 1'b0;
        check("s_hs_clk", shc, 132);
        check("s_vs_clk", svc, 128);
        check("s_von_clk", svid, 192);
        check("s_fs_clk", sfs, 2);
        check("s_maxy", smaxy, 10);
        check("s_end_x", s_px, 15);
        check("s_end_y", s_py, 10);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
